// File: rtl/stick_fsm.sv
// -----------------------------------------------------------------------------
// stick_fsm
//   Runs one game round of the stick: IDLE -> GROW -> FALL -> LANDED.
//   - GROW adds GROW_STEP per tick while the button is held and saturates at
//     MAX_LEN.
//   - FALL lasts FALL_TICKS ticks. On the last tick the hit test is evaluated
//     and the result is presented with a valid/ack handshake.
//   - The stick is also drawn into the VGA pixel stream: upright while
//     growing or falling, and lying horizontally once it has landed.
//
// Ports
//   clk           system clock
//   rst           synchronous active-low reset
//   tick          game-rate enable, one clk wide
//   up            debounced grow button (level)
//   gap_dist      distance from the stick base to the near edge of the platform
//   plat_width    width of the target platform
//   result_ack    consumer accepts the result
//   bright        pixel is inside the active display area
//   hCount        horizontal pixel counter
//   vCount        vertical pixel counter
//   background    colour used where the stick is not drawn
//   rgb           output pixel colour
//   stick_len     current stick length
//   busy          a round is in progress (state is not IDLE)
//   result_valid  round finished; the result is held
//   success       hit-test result, qualified by result_valid
// -----------------------------------------------------------------------------
module stick_fsm #(
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned GROW_STEP  = 2,
    parameter int unsigned MAX_LEN    = 216,
    parameter int unsigned HALF_W     = 2,
    parameter int unsigned FALL_TICKS = 8,
    parameter int unsigned X0         = 450,
    parameter int unsigned Y0         = 250,
    parameter logic [11:0] STICK_RGB  = 12'hF00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             up,
    input  logic [LEN_W-1:0] gap_dist,
    input  logic [LEN_W-1:0] plat_width,
    input  logic             result_ack,
    input  logic             bright,
    input  logic [9:0]       hCount,
    input  logic [9:0]       vCount,
    input  logic [11:0]      background,
    output logic [11:0]      rgb,
    output logic [LEN_W-1:0] stick_len,
    output logic             busy,
    output logic             result_valid,
    output logic             success
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GROW   = 2'd1;
    localparam logic [1:0] FALL   = 2'd2;
    localparam logic [1:0] LANDED = 2'd3;

    localparam int unsigned CNT_W = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FALL_TICKS - 1);

    localparam logic [LEN_W:0]   STEP_X   = (LEN_W + 1)'(GROW_STEP);
    localparam logic [LEN_W:0]   MAX_X    = (LEN_W + 1)'(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] FIRST_L  = LEN_W'(GROW_STEP);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             valid_q, valid_d;
    logic             success_q, success_d;

    // One extra bit so that neither the growth sum nor the far platform edge
    // can wrap around.
    logic [LEN_W:0] grow_sum;
    logic [LEN_W:0] far_edge;
    logic [LEN_W:0] len_x;

    assign len_x    = {1'b0, len_q};
    assign grow_sum = len_x + STEP_X;
    assign far_edge = {1'b0, gap_dist} + {1'b0, plat_width};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        valid_d   = valid_q;
        success_d = success_q;
        case (state_q)
            IDLE: begin
                // A button still held from the previous round must be
                // released before another round can start.
                if (!up) begin
                    armed_d = 1'b1;
                end
                if (tick && armed_q && up) begin
                    state_d = GROW;
                    len_d   = FIRST_L;
                    armed_d = 1'b0;
                end
            end
            GROW: begin
                if (tick) begin
                    if (up) begin
                        len_d = (grow_sum > MAX_X) ? MAX_L : grow_sum[LEN_W-1:0];
                    end else begin
                        state_d = FALL;
                        cnt_d   = '0;
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = LANDED;
                        valid_d   = 1'b1;
                        success_d = (len_x >= {1'b0, gap_dist}) && (len_x <= far_edge);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LANDED: begin
                // Acknowledge does not wait for a tick.
                if (valid_q && result_ack) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    success_d = 1'b0;
                    len_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            success_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            success_q <= success_d;
        end
    end

    assign stick_len    = len_q;
    assign busy         = (state_q != IDLE);
    assign result_valid = valid_q;
    assign success      = success_q;

    // Drawing. Every term is widened and only ever added, so the edges that
    // sit below X0/Y0 never underflow.
    localparam int unsigned CW = ((LEN_W > 10) ? LEN_W : 10) + 2;
    localparam logic [CW-1:0] X0_X = CW'(X0);
    localparam logic [CW-1:0] Y0_X = CW'(Y0);
    localparam logic [CW-1:0] HW_X = CW'(HALF_W);

    logic [CW-1:0] h_x, v_x, l_x;
    logic          vert_fill, horz_fill, stick_fill;

    assign h_x = CW'(hCount);
    assign v_x = CW'(vCount);
    assign l_x = CW'(len_q);

    assign vert_fill = (v_x <= Y0_X) && (v_x + l_x >= Y0_X) &&
                       (h_x + HW_X >= X0_X) && (h_x <= X0_X + HW_X);
    assign horz_fill = (h_x >= X0_X) && (h_x <= X0_X + l_x) &&
                       (v_x + HW_X >= Y0_X) && (v_x <= Y0_X + HW_X);

    always_comb begin
        stick_fill = 1'b0;
        if (len_q != '0) begin
            stick_fill = (state_q == LANDED) ? horz_fill : vert_fill;
        end
    end

    always_comb begin
        rgb = 12'h000;
        if (bright) begin
            rgb = stick_fill ? STICK_RGB : background;
        end
    end

endmodule

// File: tb/tb_stick_fsm.sv
module tb_stick_fsm;

    localparam int LEN_W      = 10;
    localparam int GROW_STEP  = 2;
    localparam int MAX_LEN    = 216;
    localparam int HALF_W     = 2;
    localparam int FALL_TICKS = 8;
    localparam int X0         = 450;
    localparam int Y0         = 250;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             up;
    logic [LEN_W-1:0] gap_dist;
    logic [LEN_W-1:0] plat_width;
    logic             result_ack;
    logic             bright;
    logic [9:0]       hCount;
    logic [9:0]       vCount;
    logic [11:0]      background;
    logic [11:0]      rgb;
    logic [LEN_W-1:0] stick_len;
    logic             busy;
    logic             result_valid;
    logic             success;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stick_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .up           (up),
        .gap_dist     (gap_dist),
        .plat_width   (plat_width),
        .result_ack   (result_ack),
        .bright       (bright),
        .hCount       (hCount),
        .vCount       (vCount),
        .background   (background),
        .rgb          (rgb),
        .stick_len    (stick_len),
        .busy         (busy),
        .result_valid (result_valid),
        .success      (success)
    );

    // Reference model: length after n held ticks, hit test, and pixel geometry.
    function automatic int model_len(int n);
        return (GROW_STEP * n > MAX_LEN) ? MAX_LEN : GROW_STEP * n;
    endfunction

    function automatic bit model_hit(int len, int gap, int width);
        return (len >= gap) && (len <= gap + width);
    endfunction

    function automatic logic [11:0] model_rgb(int h, int v, bit landed, int len, bit br,
                                              logic [11:0] bg);
        bit fill;
        if (!br) return 12'h000;
        if (len == 0) fill = 0;
        else if (landed)
            fill = (h >= X0) && (h <= X0 + len) && (v >= Y0 - HALF_W) && (v <= Y0 + HALF_W);
        else
            fill = (v >= Y0 - len) && (v <= Y0) && (h >= X0 - HALF_W) && (h <= X0 + HALF_W);
        return fill ? 12'hF00 : bg;
    endfunction

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic arm_and_grow(int n);
        up = 1'b0;
        @(negedge clk);
        up = 1'b1;
        repeat (n) do_tick();
    endtask

    // Release, then spend the fall ticks with noise on up/gap/width; only the
    // values present on the landing tick may matter.
    task automatic finish_fall(int gap, int width);
        up = 1'b0;
        do_tick();
        repeat (FALL_TICKS - 1) begin
            up         = 1'($urandom);
            gap_dist   = 10'($urandom);
            plat_width = 10'($urandom);
            do_tick();
        end
        gap_dist   = LEN_W'(gap);
        plat_width = LEN_W'(width);
        up         = 1'($urandom);
        do_tick();
        up = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        up  = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || stick_len !== '0 || result_valid !== 1'b0 || success !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: busy=%b len=%0d rv=%b succ=%b, want 0/0/0/0",
                     busy, stick_len, result_valid, success);
        end
        rst = 1'b1;
        repeat (5) do_tick();
        tests++;
        if (busy !== 1'b0 || stick_len !== '0) begin
            fails++;
            $display("FAIL held_button_no_start: busy=%b len=%0d, want 0/0", busy, stick_len);
        end
    endtask

    task automatic test_basic_round();
        arm_and_grow(10);
        tests++;
        if (stick_len !== 10'd20 || busy !== 1'b1) begin
            fails++;
            $display("FAIL grow_len: len=%0d busy=%b, want 20/1", stick_len, busy);
        end
        // Acknowledge with no result pending must do nothing.
        @(negedge clk);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        tests++;
        if (stick_len !== 10'd20 || busy !== 1'b1 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_ack: len=%0d busy=%b rv=%b, want 20/1/0",
                     stick_len, busy, result_valid);
        end
        up = 1'b0;
        do_tick();
        repeat (FALL_TICKS - 1) begin
            up = 1'($urandom);
            do_tick();
        end
        tests++;
        if (result_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_result: rv=%b after %0d ticks, want 0", result_valid, FALL_TICKS);
        end
        gap_dist   = 10'd20;
        plat_width = 10'd30;
        do_tick();
        up = 1'b0;
        tests++;
        if (result_valid !== 1'b1 || success !== 1'b1 || stick_len !== 10'd20) begin
            fails++;
            $display("FAIL landing: rv=%b succ=%b len=%0d, want 1/1/20",
                     result_valid, success, stick_len);
        end
        gap_dist = 10'd999;
        do_tick();
        tests++;
        if (result_valid !== 1'b1 || success !== 1'b1 || stick_len !== 10'd20) begin
            fails++;
            $display("FAIL result_hold: rv=%b succ=%b len=%0d, want 1/1/20",
                     result_valid, success, stick_len);
        end
        do_ack();
        tests++;
        if (result_valid !== 1'b0 || success !== 1'b0 || stick_len !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ack_clear: rv=%b succ=%b len=%0d busy=%b, want 0/0/0/0",
                     result_valid, success, stick_len, busy);
        end
    endtask

    task automatic test_hits();
        int ns[3]  = '{10, 10, 10};
        int gs[3]  = '{20, 21, 0};
        int ws[3]  = '{30, 30, 20};
        for (int i = 0; i < 11; i++) begin
            int n, len, gap, width;
            bit exp;
            if (i < 3) begin
                n = ns[i]; gap = gs[i]; width = ws[i];
            end else begin
                n     = int'($urandom_range(1, 130));
                width = int'($urandom_range(0, 60));
                if ($urandom_range(0, 1) == 1) begin
                    gap = model_len(n) - int'($urandom_range(0, 70));
                    if (gap < 0) gap = 0;
                end else begin
                    gap = int'($urandom_range(0, 400));
                end
            end
            len = model_len(n);
            exp = model_hit(len, gap, width);
            arm_and_grow(n);
            finish_fall(gap, width);
            tests++;
            if (result_valid !== 1'b1 || success !== exp || int'(stick_len) != len) begin
                fails++;
                $display("FAIL hit_%0d: rv=%b succ=%b len=%0d, want 1/%b/%0d (gap=%0d w=%0d)",
                         i, result_valid, success, stick_len, exp, len, gap, width);
            end
            do_ack();
        end
    endtask

    task automatic test_saturation();
        up = 1'b0;
        @(negedge clk);
        up = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            do_tick();
            tests++;
            if (int'(stick_len) != model_len(i)) begin
                fails++;
                $display("FAIL sat_len_%0d: len=%0d, want %0d", i, stick_len, model_len(i));
            end
        end
        finish_fall(200, 20);
        tests++;
        if (stick_len !== 10'd216 || result_valid !== 1'b1 || success !== 1'b1) begin
            fails++;
            $display("FAIL sat_land: len=%0d rv=%b succ=%b, want 216/1/1",
                     stick_len, result_valid, success);
        end
        do_ack();
    endtask

    task automatic test_draw();
        logic [11:0] exp;
        arm_and_grow(10);
        finish_fall(20, 30);
        background = 12'h0A5;
        bright = 1'b1; hCount = 10'd460; vCount = 10'd250; #1;
        tests++;
        if (rgb !== 12'hF00) begin
            fails++;
            $display("FAIL draw_on: rgb=%h, want f00", rgb);
        end
        hCount = 10'd471; #1;
        tests++;
        if (rgb !== 12'h0A5) begin
            fails++;
            $display("FAIL draw_off: rgb=%h, want 0a5", rgb);
        end
        bright = 1'b0; hCount = 10'd460; #1;
        tests++;
        if (rgb !== 12'h000) begin
            fails++;
            $display("FAIL draw_blank: rgb=%h, want 000", rgb);
        end
        for (int i = 0; i < 40; i++) begin
            bright     = ($urandom_range(0, 7) != 0);
            background = 12'($urandom);
            hCount     = 10'(X0 - 6 + int'($urandom_range(0, 32)));
            vCount     = 10'(Y0 - 6 + int'($urandom_range(0, 12)));
            #1;
            exp = model_rgb(int'(hCount), int'(vCount), 1'b1, 20, bright, background);
            tests++;
            if (rgb !== exp) begin
                fails++;
                $display("FAIL draw_h_%0d (%0d,%0d): rgb=%h, want %h",
                         i, hCount, vCount, rgb, exp);
            end
        end
        do_ack();
        // Zero length draws nothing.
        bright = 1'b1; background = 12'h123; hCount = 10'd450; vCount = 10'd250; #1;
        tests++;
        if (rgb !== 12'h123) begin
            fails++;
            $display("FAIL draw_zero: rgb=%h, want 123", rgb);
        end
        arm_and_grow(15);
        for (int i = 0; i < 40; i++) begin
            bright     = ($urandom_range(0, 7) != 0);
            background = 12'($urandom);
            hCount     = 10'(X0 - 6 + int'($urandom_range(0, 12)));
            vCount     = 10'(Y0 - 36 + int'($urandom_range(0, 42)));
            #1;
            exp = model_rgb(int'(hCount), int'(vCount), 1'b0, 30, bright, background);
            tests++;
            if (rgb !== exp) begin
                fails++;
                $display("FAIL draw_v_%0d (%0d,%0d): rgb=%h, want %h",
                         i, hCount, vCount, rgb, exp);
            end
        end
        finish_fall(0, 0);
        do_ack();
    endtask

    task automatic test_reset_mid();
        arm_and_grow(5);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tests++;
        if (busy !== 1'b0 || stick_len !== '0 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_grow: busy=%b len=%0d rv=%b, want 0/0/0",
                     busy, stick_len, result_valid);
        end
        arm_and_grow(12);
        finish_fall(24, 0);
        tests++;
        if (result_valid !== 1'b1 || success !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_land: rv=%b succ=%b, want 1/1", result_valid, success);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tests++;
        if (busy !== 1'b0 || stick_len !== '0 || result_valid !== 1'b0 || success !== 1'b0) begin
            fails++;
            $display("FAIL reset_landed: busy=%b len=%0d rv=%b succ=%b, want 0/0/0/0",
                     busy, stick_len, result_valid, success);
        end
    endtask

    initial begin
        rst        = 1'b0;
        tick       = 1'b0;
        up         = 1'b1;
        gap_dist   = '0;
        plat_width = '0;
        result_ack = 1'b0;
        bright     = 1'b1;
        hCount     = '0;
        vCount     = '0;
        background = 12'h0A5;
        test_reset();
        test_basic_round();
        test_hits();
        test_saturation();
        test_draw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
